// File: rtl/apb_master_bridge_if.sv
// APB bus bundle between the bridge (master) and its NUM_SLV peripherals.
// PSEL is one-hot per slave; PRDATA/PREADY are concatenated per slave.
interface apb_master_bridge_if #(
   parameter int unsigned NUM_SLV = 4
);
   logic [31:0]           PADDR;
   logic                  PWRITE;
   logic [31:0]           PWDATA;
   logic                  PENABLE;
   logic [NUM_SLV-1:0]    PSEL;
   logic [32*NUM_SLV-1:0] PRDATA_ALL;
   logic [NUM_SLV-1:0]    PREADY_ALL;

   modport master (
      output PADDR, PWRITE, PWDATA, PENABLE, PSEL,
      input  PRDATA_ALL, PREADY_ALL
   );

   modport slave (
      input  PADDR, PWRITE, PWDATA, PENABLE, PSEL,
      output PRDATA_ALL, PREADY_ALL
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 master bridge.
// Accepts a simple request in IDLE, decodes it to one of NUM_SLV 4 KB slave
// windows, runs SETUP/ACCESS on the APB bus and returns a one-cycle done/err
// pulse. Decode misses and PREADY timeouts complete with err=1.
module apb_master_bridge #(
   parameter int unsigned NUM_SLV   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int unsigned SLV_AW    = 12,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic                       transfer,
   input  logic                       write,
   input  logic [31:0]                addr,
   input  logic [31:0]                wdata,
   output logic                       req_ready,
   output logic                       done,
   output logic                       err,
   output logic [31:0]                rdata,
   apb_master_bridge_if.master        apb
);

   localparam int unsigned IW = $clog2(NUM_SLV);
   localparam int unsigned HB = SLV_AW + IW;
   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ERR    = 2'd3;

   logic [1:0]    state_q,  state_d;
   logic [IW-1:0] idx_q,    idx_d;
   logic [31:0]   paddr_q,  paddr_d;
   logic          pwrite_q, pwrite_d;
   logic [31:0]   pwdata_q, pwdata_d;
   logic [CW-1:0] cnt_q,    cnt_d;
   logic          done_q,   done_d;
   logic          err_q,    err_d;
   logic [31:0]   rdata_q,  rdata_d;

   logic               addr_hit;
   logic [IW-1:0]      addr_idx;
   logic               sel_ready;
   logic [31:0]        sel_rdata;
   logic [NUM_SLV-1:0] psel;
   logic               penable;

   // Address decode of the incoming request (only used at accept)
   always_comb begin
      addr_hit = (addr[31:HB] == BASE_ADDR[31:HB]);
      addr_idx = addr[SLV_AW +: IW];
   end

   // Return-path mux: only the latched slave's PREADY/PRDATA are observed
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         if (idx_q == IW'(i)) begin
            sel_ready = apb.PREADY_ALL[i];
            sel_rdata = apb.PRDATA_ALL[32*i +: 32];
         end
      end
   end

   // Next-state, request latching, timeout count and completion generation
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               idx_d    = addr_idx;
               paddr_d  = addr;
               pwrite_d = write;
               pwdata_d = wdata;
               if (addr_hit) begin
                  state_d = ST_SETUP;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end

         ST_SETUP: begin
            state_d = ST_ACCESS;
         end

         ST_ACCESS: begin
            if (sel_ready) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               if (!pwrite_q) begin
                  rdata_d = sel_rdata;
               end
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_ERR: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops the bus asynchronously
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // PSEL/PENABLE decoded from the state flops so reset clears them at once
   always_comb begin
      psel    = '0;
      penable = 1'b0;
      if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
         psel[idx_q] = 1'b1;
      end
      if (state_q == ST_ACCESS) begin
         penable = 1'b1;
      end
   end

   assign apb.PSEL    = psel;
   assign apb.PENABLE = penable;
   assign apb.PADDR   = paddr_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PWDATA  = pwdata_q;

   assign req_ready = (state_q == ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: four slave models (slave 2 never
// ready), expected completions queued at request time and checked at done.
module tb_apb_master_bridge;

   localparam int unsigned NSLV = 4;
   localparam logic [3:0]  RDY_EN = 4'b1011;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        transfer;
   logic        write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        req_ready;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic [3:0]  pready_q;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  sel;
      int          lat;
      int          pen;
   } exp_t;

   exp_t sb[$];

   apb_master_bridge_if #(.NUM_SLV(NSLV)) apb ();

   apb_master_bridge #(
      .NUM_SLV   (NSLV),
      .BASE_ADDR (32'h1000_0000),
      .SLV_AW    (12),
      .TIMEOUT   (16)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .transfer  (transfer),
      .write     (write),
      .addr      (addr),
      .wdata     (wdata),
      .req_ready (req_ready),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .apb       (apb)
   );

   always #5 PCLK = ~PCLK;

   // Slave models: PREADY registered one cycle after PSEL&PENABLE
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) pready_q <= '0;
      else        pready_q <= apb.PSEL & {4{apb.PENABLE}} & RDY_EN;
   end

   assign apb.PREADY_ALL = pready_q;
   assign apb.PRDATA_ALL = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0005};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Issue one request from a negedge, follow it to done, compare with queue head
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] e_sel, input int e_lat, input int e_pen,
                       input logic e_err, input logic [31:0] e_rd, input int pulse_cyc);
      exp_t       e;
      int         cyc;
      int         pen_n;
      int         sel_n;
      logic [3:0] sel_or;
      logic       bus_bad;
      logic       seen;
      e.err = e_err; e.rdata = e_rd; e.sel = e_sel; e.lat = e_lat; e.pen = e_pen;
      sb.push_back(e);
      transfer = 1'b1; write = wr; addr = a; wdata = d;
      cyc = 0; pen_n = 0; sel_n = 0; sel_or = '0; bus_bad = 1'b0; seen = 1'b0;
      while (!seen && cyc < 60) begin
         @(negedge PCLK);
         cyc++;
         if (pulse_cyc != 0 && cyc == pulse_cyc) begin
            transfer = 1'b1; write = ~wr; addr = 32'h1000_3000; wdata = 32'hBAD0_BAD0;
         end else begin
            transfer = 1'b0;
         end
         if (apb.PSEL != '0) begin
            sel_n++;
            sel_or |= apb.PSEL;
            if (apb.PADDR !== a || apb.PWRITE !== wr || (wr && apb.PWDATA !== d)) bus_bad = 1'b1;
         end
         if (!$onehot0(apb.PSEL)) bus_bad = 1'b1;
         if (apb.PENABLE) begin
            pen_n++;
            if (apb.PSEL == '0) bus_bad = 1'b1;
         end
         if (err && !done) bus_bad = 1'b1;
         if (done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      e = sb.pop_front();
      if (seen) begin
         chk("latency", 32'(cyc), 32'(e.lat));
         chk("err", 32'(err), 32'(e.err));
         chk("rdata", rdata, e.rdata);
         chk("psel", 32'(sel_or), 32'(e.sel));
         chk("penable_cycles", 32'(pen_n), 32'(e.pen));
         chk("psel_cycles", 32'(sel_n), (e.sel != '0) ? 32'(e.pen + 1) : 32'd0);
         chk("bus_protocol", 32'(bus_bad), 32'd0);
      end
   endtask

   // Quiet-bus window: no completion and no select for n cycles
   task automatic idle_check(input int n);
      int dn;
      int busy;
      dn = 0; busy = 0;
      repeat (n) begin
         @(negedge PCLK);
         if (done || err) dn++;
         if (apb.PSEL != '0 || apb.PENABLE) busy++;
      end
      chk("idle_done", 32'(dn), 32'd0);
      chk("idle_bus", 32'(busy), 32'd0);
   endtask

   initial begin
      PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(negedge PCLK);
      chk("rst_psel", 32'(apb.PSEL), 32'd0);
      chk("rst_penable", 32'(apb.PENABLE), 32'd0);
      chk("rst_paddr", apb.PADDR, 32'd0);
      chk("rst_pwrite", 32'(apb.PWRITE), 32'd0);
      chk("rst_pwdata", apb.PWDATA, 32'd0);
      chk("rst_done_err", {30'd0, done, err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      PRESET = 1'b0;
      @(negedge PCLK);

      // Write to slave 0
      xfer(1'b1, 32'h1000_0000, 32'h0000_000F, 4'b0001, 4, 2, 1'b0, 32'h0, 0);
      idle_check(2);
      chk("hold_paddr", apb.PADDR, 32'h1000_0000);
      chk("hold_pwdata", apb.PWDATA, 32'h0000_000F);

      // Read slave 0, then write slave 1 leaves rdata alone
      xfer(1'b0, 32'h1000_0004, 32'h0, 4'b0001, 4, 2, 1'b0, 32'h5, 0);
      xfer(1'b1, 32'h1000_1000, 32'hDEAD_BEEF, 4'b0010, 4, 2, 1'b0, 32'h5, 0);
      idle_check(1);
      // Last word of the region selects slave 3
      xfer(1'b0, 32'h1000_3FFC, 32'h0, 4'b1000, 4, 2, 1'b0, 32'h3333_3333, 0);
      xfer(1'b0, 32'h1000_1008, 32'h0, 4'b0010, 4, 2, 1'b0, 32'h1111_1111, 0);

      // Decode misses: far away and just past the region
      xfer(1'b0, 32'h2000_0000, 32'h0, 4'b0000, 2, 0, 1'b1, 32'h1111_1111, 0);
      idle_check(1);
      xfer(1'b0, 32'h1000_4000, 32'h0, 4'b0000, 2, 0, 1'b1, 32'h1111_1111, 0);
      idle_check(1);

      // Slave 2 never ready: 16 ACCESS cycles then timeout
      xfer(1'b0, 32'h1000_2000, 32'h0, 4'b0100, 18, 16, 1'b1, 32'h1111_1111, 0);
      idle_check(3);

      // Back-to-back: second request driven during the done cycle
      xfer(1'b1, 32'h1000_0000, 32'h0000_0001, 4'b0001, 4, 2, 1'b0, 32'h1111_1111, 0);
      xfer(1'b0, 32'h1000_0000, 32'h0, 4'b0001, 4, 2, 1'b0, 32'h5, 0);
      idle_check(1);

      // Request strobe during ACCESS is dropped
      xfer(1'b0, 32'h1000_1004, 32'h0, 4'b0010, 4, 2, 1'b0, 32'h1111_1111, 2);
      idle_check(4);

      // Reset during ACCESS: bus drops immediately, no completion
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_0000;
      @(negedge PCLK);
      transfer = 1'b0;
      @(negedge PCLK);
      chk("pre_rst_penable", 32'(apb.PENABLE), 32'd1);
      #2 PRESET = 1'b1;
      #1;
      chk("async_psel", 32'(apb.PSEL), 32'd0);
      chk("async_penable", 32'(apb.PENABLE), 32'd0);
      @(negedge PCLK);
      PRESET = 1'b0;
      idle_check(4);
      chk("post_rst_rdata", rdata, 32'd0);
      xfer(1'b0, 32'h1000_1000, 32'h0, 4'b0010, 4, 2, 1'b0, 32'h1111_1111, 0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
